// File: rtl/pulse_counter_readout_ctrl.sv
// Readout scheduler: RTC tick -> snapshot, then per channel LOAD + COUNT_W shifts; optional CH_MASK_EN skips masked channels.
// Latency: snap_o 3 clk after rtc_in rises; frame busy for 1+N*(1+COUNT_W) cycles.
// No backpressure: ticks arriving mid-frame are dropped and flagged on sticky ovf_rtc_o.
module pulse_counter_readout_ctrl #(
    parameter int NUM_CH  = 4,
    parameter int COUNT_W = 16,
    parameter int ADDR_W  = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rtc_in,
    input  logic [NUM_CH-1:0] ovf_ch,
`ifdef CH_MASK_EN
    input  logic [NUM_CH-1:0] ch_mask,
`endif
    input  logic              ovf_clr,
    output logic              snap_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic              sl_o,
    output logic              shift_en_o,
    output logic              ovf_ch_o,
    output logic              ovf_rtc_o,
    output logic              busy_o
);

    localparam int BIT_W = (COUNT_W > 1) ? $clog2(COUNT_W) : 1;

    typedef enum logic [1:0] {IDLE, SNAP, LOAD, SHIFT} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] ch, ch_nxt;
    logic [BIT_W-1:0]  bit_cnt, bit_nxt;
    logic              rtc_s1, rtc_s2, rtc_prev, rtc_edge;
    logic [NUM_CH-1:0] snap_mask, run_mask;
    logic [ADDR_W:0]   nc;
    logic              ovf_sel;
    logic              ovf_ch_d;

`ifdef CH_MASK_EN
    logic [NUM_CH-1:0] mask_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)              mask_q <= '0;
        else if (state == SNAP)  mask_q <= ch_mask;
    end

    assign snap_mask = ch_mask;
    assign run_mask  = mask_q;
`else
    assign snap_mask = '1;
    assign run_mask  = '1;
`endif

    // Lowest enabled channel index >= from; MSB flags that one exists.
    function automatic logic [ADDR_W:0] next_ch(input logic [NUM_CH-1:0] m, input int from);
        logic [ADDR_W:0] r;
        r = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (m[i] && i >= from) r = {1'b1, ADDR_W'(i)};
        end
        return r;
    endfunction

    assign rtc_edge = rtc_s2 & ~rtc_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        ch_nxt    = ch;
        bit_nxt   = bit_cnt;
        nc        = '0;
        case (state)
            IDLE: if (rtc_edge) state_nxt = SNAP;
            SNAP: begin
                nc = next_ch(snap_mask, 0);
                if (nc[ADDR_W]) begin
                    state_nxt = LOAD;
                    ch_nxt    = nc[ADDR_W-1:0];
                end else begin
                    state_nxt = IDLE;
                end
            end
            LOAD: begin
                bit_nxt   = '0;
                state_nxt = SHIFT;
            end
            SHIFT: begin
                if (bit_cnt == BIT_W'(COUNT_W - 1)) begin
                    nc = next_ch(run_mask, int'(ch) + 1);
                    if (nc[ADDR_W]) begin
                        state_nxt = LOAD;
                        ch_nxt    = nc[ADDR_W-1:0];
                    end else begin
                        state_nxt = IDLE;
                        ch_nxt    = '0;
                    end
                end else begin
                    bit_nxt = bit_cnt + BIT_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ovf_sel = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ch == ADDR_W'(i)) ovf_sel = ovf_ch[i];
        end
    end

    // Flag is captured at the end of LOAD, held through SHIFT and zero otherwise.
    assign ovf_ch_d = (state == LOAD) ? ovf_sel : ((state_nxt == SHIFT) ? ovf_ch_o : 1'b0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rtc_s1     <= 1'b1;
            rtc_s2     <= 1'b1;
            rtc_prev   <= 1'b1;
            ch         <= '0;
            bit_cnt    <= '0;
            snap_o     <= 1'b0;
            addr_o     <= '0;
            sl_o       <= 1'b0;
            shift_en_o <= 1'b0;
            ovf_ch_o   <= 1'b0;
            ovf_rtc_o  <= 1'b0;
            busy_o     <= 1'b0;
        end else begin
            rtc_s1     <= rtc_in;
            rtc_s2     <= rtc_s1;
            rtc_prev   <= rtc_s2;
            ch         <= ch_nxt;
            bit_cnt    <= bit_nxt;
            snap_o     <= (state_nxt == SNAP);
            sl_o       <= (state_nxt == LOAD);
            shift_en_o <= (state_nxt == SHIFT);
            busy_o     <= (state_nxt != IDLE);
            addr_o     <= (state_nxt == LOAD || state_nxt == SHIFT) ? ch_nxt : '0;
            ovf_ch_o   <= ovf_ch_d;
            // Set dominates a simultaneous clear.
            if (rtc_edge && state != IDLE) ovf_rtc_o <= 1'b1;
            else if (ovf_clr)              ovf_rtc_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pulse_counter_readout_ctrl.sv
// Scoreboard bench: stimulus pushes per-cycle expected frame outputs; a negedge monitor pops and compares.
module tb_pulse_counter_readout_ctrl;

    localparam int NUM_CH  = 4;
    localparam int COUNT_W = 16;
    localparam int ADDR_W  = 3;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              rtc_in = 1'b1;
    logic              ovf_clr = 1'b0;
    logic [NUM_CH-1:0] ovf_ch = '0;
`ifdef CH_MASK_EN
    logic [NUM_CH-1:0] ch_mask = '1;
`endif
    logic              snap_o, sl_o, shift_en_o, ovf_ch_o, ovf_rtc_o, busy_o;
    logic [ADDR_W-1:0] addr_o;

    pulse_counter_readout_ctrl #(.NUM_CH(NUM_CH), .COUNT_W(COUNT_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .rtc_in(rtc_in),
        .ovf_ch(ovf_ch),
`ifdef CH_MASK_EN
        .ch_mask(ch_mask),
`endif
        .ovf_clr(ovf_clr),
        .snap_o(snap_o),
        .addr_o(addr_o),
        .sl_o(sl_o),
        .shift_en_o(shift_en_o),
        .ovf_ch_o(ovf_ch_o),
        .ovf_rtc_o(ovf_rtc_o),
        .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct packed {
        logic              snap;
        logic              sl;
        logic              shift;
        logic              ovf;
        logic [ADDR_W-1:0] addr;
    } outs_t;

    typedef struct packed {
        int    at;
        outs_t o;
    } exp_t;

    exp_t exp_q[$];
    int   set_q[$];
    int   clr_q[$];
    int   checks = 0;
    int   errors = 0;
    int   busy_end = 0;
    int   last_start = 0;
    logic exp_rtc = 1'b0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, got, want);
        end
    endtask

    // Monitor: lockstep against the expected-output queue.
    always @(negedge clk) begin
        outs_t act;
        exp_t  e;
        logic  exp_busy;
        act = '{snap_o, sl_o, shift_en_o, ovf_ch_o, addr_o};
        if (!rst_n) begin
            exp_rtc = 1'b0;
            chk("reset_outs", {23'd0, busy_o, ovf_rtc_o, act}, 32'd0);
        end else begin
            while (clr_q.size() > 0 && clr_q[0] <= cyc) begin
                void'(clr_q.pop_front());
                exp_rtc = 1'b0;
            end
            while (set_q.size() > 0 && set_q[0] <= cyc) begin
                void'(set_q.pop_front());
                exp_rtc = 1'b1;
            end
            chk("ovf_rtc_o", 32'(ovf_rtc_o), 32'(exp_rtc));
            exp_busy = (exp_q.size() > 0) && (exp_q[0].at <= cyc);
            chk("busy_o", 32'(busy_o), 32'(exp_busy));
            if (exp_busy) begin
                e = exp_q.pop_front();
                chk("frame_outs", 32'(act), 32'(e.o));
            end else begin
                chk("idle_outs", 32'(act), 32'd0);
            end
        end
    end

    task automatic advance(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic goto(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clr_pulse();
        ovf_clr = 1'b1;
        clr_q.push_back(cyc + 1);
        advance(1);
        ovf_clr = 1'b0;
    endtask

    // Reference model: an rtc_in rise at cycle k is seen as an edge in cycle k+2;
    // if the controller is idle then, SNAP appears at k+3, otherwise the tick is dropped.
    task automatic tick(input logic [NUM_CH-1:0] ovf, input logic [NUM_CH-1:0] mask);
        int                k;
        int                len;
        exp_t              e;
        logic [NUM_CH-1:0] m;
        k = cyc;
        rtc_in = 1'b1;
        if (k + 2 >= busy_end) begin
`ifdef CH_MASK_EN
            ch_mask = mask;
            m = mask;
`else
            m = '1;
            if (mask == '0) m = '1;
`endif
            ovf_ch = ovf;
            last_start = k + 3;
            len = 0;
            e = '0;
            e.at = last_start;
            e.o.snap = 1'b1;
            exp_q.push_back(e);
            len++;
            for (int c = 0; c < NUM_CH; c++) begin
                if (m[c]) begin
                    e = '0;
                    e.at = last_start + len;
                    e.o.sl = 1'b1;
                    e.o.addr = ADDR_W'(c);
                    exp_q.push_back(e);
                    len++;
                    for (int b = 0; b < COUNT_W; b++) begin
                        e = '0;
                        e.at = last_start + len;
                        e.o.shift = 1'b1;
                        e.o.addr = ADDR_W'(c);
                        e.o.ovf = ovf[c];
                        exp_q.push_back(e);
                        len++;
                    end
                end
            end
            busy_end = last_start + len;
        end else begin
            set_q.push_back(k + 3);
        end
        advance(3);
        rtc_in = 1'b0;
        advance(3);
    endtask

    initial begin
        // Reset released with rtc_in already high: no frame may start.
        advance(3);
        rst_n = 1'b1;
        advance(200);
        rtc_in = 1'b0;
        advance(5);

        // Plain frame, then a frame with channel 2 overflowing.
        tick('0, '1);
        goto(busy_end + 3);
        tick(4'b0100, '1);
        goto(busy_end + 3);

        // Tick mid-frame is dropped; sticky flag until cleared; next tick runs normally.
        tick('0, '1);
        goto(last_start + 38);
        tick('0, '1);
        goto(busy_end + 10);
        clr_pulse();
        advance(3);
        tick(4'b1001, '1);
        goto(busy_end + 3);

        // Edge seen in the final SHIFT cycle is dropped; one cycle later is accepted.
        tick('0, '1);
        goto(busy_end - 3);
        tick('1, '1);
        goto(busy_end + 3);
        clr_pulse();
        advance(2);
        tick(4'b0010, '1);
        goto(busy_end - 2);
        tick(4'b1000, '1);
        goto(busy_end + 3);

        // Dropped edge and ovf_clr in the same cycle: the set wins.
        tick('0, '1);
        goto(last_start + 30);
        fork
            tick('0, '1);
            begin
                advance(2);
                clr_pulse();
            end
        join
        goto(busy_end + 3);
        clr_pulse();
        advance(2);

        // Asynchronous reset mid-frame, then a full frame afterwards.
        tick(4'b0110, '1);
        goto(last_start + 20);
        rst_n = 1'b0;
        exp_q.delete();
        set_q.delete();
        clr_q.delete();
        busy_end = 0;
        advance(3);
        rst_n = 1'b1;
        advance(5);
        tick(4'b0001, '1);
        goto(busy_end + 3);

`ifdef CH_MASK_EN
        tick(4'b1111, 4'b1010);
        goto(busy_end + 3);
        tick('0, 4'b0000);
        goto(busy_end + 3);
`endif

        // Randomized ticks, gaps and clears.
        for (int i = 0; i < 40; i++) begin
            advance($urandom_range(0, 75));
            if ($urandom_range(0, 3) == 0) clr_pulse();
            tick(NUM_CH'($urandom), NUM_CH'($urandom));
        end
        goto(busy_end + 5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
